intr_controller: RTL and testbench
==================================

Name: intr_controller

Overview:
- CPU-side receiver for the button interrupt pulse produced by the press/debounce FSM.
- Detects the rising edge of the pulse, whose high time is several cycles, and latches it as a pending interrupt.
- Presents a level request to the CPU control FSM, gated by the CSR interrupt enable, and tracks the trap handshake: CPU acknowledge on trap entry, mret on exit.
- Counts edges that could not be queued, so software can detect lost presses.

Parameters:
- CNT_W, 8: width of the saturating missed-interrupt counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- intr_in  in  1  interrupt line from the button FSM; level, high for 1..N consecutive cycles per event.
- mie  in  1  CSR interrupt-enable bit; gates cpu_intr only, never the latching.
- cpu_ack  in  1  one-cycle strobe; CPU has entered the trap for this request.
- mret  in  1  one-cycle strobe; CPU has executed mret.
- clr_missed  in  1  synchronous clear of missed_cnt.
- cpu_intr  out  1  interrupt request to the CPU FSM.
- pending  out  1  an interrupt is latched and not yet acknowledged.
- in_service  out  1  the handler is running (between cpu_ack and mret).
- missed_cnt  out  CNT_W  saturating count of dropped edges.
- proto_err  out  1  sticky flag for an illegal handshake; cleared only by reset.

Behaviour:
- Edge detect: prev_r registers intr_in each cycle. edge = intr_in & ~prev_r.
  - prev_r resets to 1, so a line held high through reset release produces no edge.
  - A multi-cycle-high pulse yields exactly one edge.
- States (enum): IDLE, PEND, SERVICE. Reset values: state=IDLE, repend=0, missed_cnt=0, proto_err=0. All outputs reset to 0.
- Output decode (from registered state):
  - pending = (state==PEND).
  - in_service = (state==SERVICE).
  - cpu_intr = pending & mie. Combinational from registered state and mie, so mie deasserting drops the request in the same cycle.
- Latency: edge sampled at clock edge N gives pending=1 after edge N, so cpu_intr is visible in cycle N+1.
- IDLE:
  - edge -> PEND.
  - cpu_ack or mret while IDLE -> proto_err=1; state unchanged.
- PEND:
  - cpu_ack -> SERVICE. cpu_ack is honoured only when cpu_intr=1; cpu_ack with mie=0 -> proto_err=1, stay PEND.
  - edge without cpu_ack -> missed_cnt+1 (coalesced into the existing pending interrupt).
  - edge and valid cpu_ack in the same cycle -> SERVICE with repend=1; no miss counted.
  - mret -> proto_err=1; ignored.
- SERVICE:
  - edge with repend=0 -> repend=1.
  - edge with repend=1 -> missed_cnt+1.
  - mret -> PEND if (repend | edge), else IDLE. repend cleared on exit.
  - cpu_ack -> proto_err=1; ignored.
- missed_cnt saturates at 2^CNT_W-1 with no wrap.
  - clr_missed has priority over a same-cycle increment: result is 0.
- Asynchronous reset mid-operation (any state) returns everything to reset values immediately. A pending request is discarded, not replayed.
- No combinational path from intr_in to any output.

Decomposition:
- Package intr_pkg holds:
  - typedef enum logic [1:0] {IDLE, PEND, SERVICE} intr_state_t, with explicit encodings 0/1/2.
  - Default for CNT_W.
  - Encoding 3 is unreachable; the case default forces the next state to IDLE and sets proto_err.
- One sub-module, edge_rise: registered rising-edge detector with a reset-value parameter. The FSM and counter stay in intr_controller.

Test Plan:
- Reset release with intr_in=1, then hold 10 cycles -> no pending, cpu_intr=0, missed_cnt=0.
- intr_in high for 6 cycles with mie=1 -> pending=1 one cycle after the first high sample; cpu_intr=1. Pulse cpu_ack -> in_service=1, cpu_intr=0. Pulse mret -> IDLE.
- mie=0, pulse intr_in -> pending=1, cpu_intr=0. Raise mie -> cpu_intr=1 the same cycle. cpu_ack while mie=0 (before raising) -> proto_err=1.
- Three edges in PEND, then ack, then two edges in SERVICE -> missed_cnt=3 (2 in PEND, 1 in SERVICE). mret -> PEND.
- CNT_W=2, drive 6 extra edges in PEND -> missed_cnt sticks at 3. clr_missed together with an edge -> missed_cnt=0.
- Assert rst_n=0 mid-SERVICE with repend=1 -> all outputs 0 asynchronously, state IDLE after release.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared types and defaults for the button interrupt controller.
// State encoding 3 is unused and treated as a fault by the FSM.
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        SERVICE = 2'd2
    } intr_state_t;

    localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector; the history register resets to RST_VAL so a
// line already high at reset release can be masked.
module edge_rise #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= RST_VAL;
        end else begin
            prev_reg <= d;
        end
    end

    assign rise = d & ~prev_reg;

endmodule

// File: rtl/intr_controller.sv
// CPU-side receiver for the debounced button interrupt: latches one pending
// request, tracks the ack/mret trap handshake and counts edges it had to drop.
module intr_controller
    import intr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             intr_in,
    input  logic             mie,
    input  logic             cpu_ack,
    input  logic             mret,
    input  logic             clr_missed,
    output logic             cpu_intr,
    output logic             pending,
    output logic             in_service,
    output logic [CNT_W-1:0] missed_cnt,
    output logic             proto_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    intr_state_t      state_reg, state_next;
    logic             repend_reg, repend_next;
    logic [CNT_W-1:0] missed_reg, missed_next;
    logic             proto_err_reg, proto_err_next;
    logic             rise;
    logic             miss_inc;

    edge_rise #(
        .RST_VAL(1'b1)
    ) u_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (intr_in),
        .rise (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            repend_reg    <= 1'b0;
            missed_reg    <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            repend_reg    <= repend_next;
            missed_reg    <= missed_next;
            proto_err_reg <= proto_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        repend_next    = repend_reg;
        proto_err_next = proto_err_reg;
        miss_inc       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rise) begin
                    state_next = PEND;
                end
                if (cpu_ack || mret) begin
                    proto_err_next = 1'b1;
                end
            end

            PEND: begin
                // An ack is only legal while the request is actually visible.
                if (cpu_ack && mie) begin
                    state_next  = SERVICE;
                    repend_next = rise;
                end else if (rise) begin
                    miss_inc = 1'b1;
                end
                if ((cpu_ack && !mie) || mret) begin
                    proto_err_next = 1'b1;
                end
            end

            SERVICE: begin
                if (rise) begin
                    if (repend_reg) begin
                        miss_inc = 1'b1;
                    end else begin
                        repend_next = 1'b1;
                    end
                end
                if (mret) begin
                    state_next  = (repend_reg || rise) ? PEND : IDLE;
                    repend_next = 1'b0;
                end
                if (cpu_ack) begin
                    proto_err_next = 1'b1;
                end
            end

            default: begin
                state_next     = IDLE;
                repend_next    = 1'b0;
                proto_err_next = 1'b1;
            end
        endcase

        if (clr_missed) begin
            missed_next = '0;
        end else if (miss_inc && (missed_reg != CNT_MAX)) begin
            missed_next = missed_reg + 1'b1;
        end else begin
            missed_next = missed_reg;
        end
    end

    always_comb begin
        pending    = (state_reg == PEND);
        in_service = (state_reg == SERVICE);
        cpu_intr   = pending & mie;
    end

    assign missed_cnt = missed_reg;
    assign proto_err  = proto_err_reg;

endmodule

// File: tb/tb_intr_controller.sv
// Directed self-checking bench for intr_controller; a second instance with a
// 2-bit counter shares the stimulus to exercise saturation.
module tb_intr_controller;

    logic       clk;
    logic       rst_n;
    logic       intr_in;
    logic       mie;
    logic       cpu_ack;
    logic       mret;
    logic       clr_missed;
    logic       cpu_intr;
    logic       pending;
    logic       in_service;
    logic [7:0] missed_cnt;
    logic       proto_err;
    logic       sat_cpu_intr;
    logic       sat_pending;
    logic       sat_in_service;
    logic [1:0] sat_missed_cnt;
    logic       sat_proto_err;

    int checks = 0;
    int errors = 0;

    intr_controller #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .intr_in   (intr_in),
        .mie       (mie),
        .cpu_ack   (cpu_ack),
        .mret      (mret),
        .clr_missed(clr_missed),
        .cpu_intr  (cpu_intr),
        .pending   (pending),
        .in_service(in_service),
        .missed_cnt(missed_cnt),
        .proto_err (proto_err)
    );

    intr_controller #(.CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .intr_in   (intr_in),
        .mie       (mie),
        .cpu_ack   (cpu_ack),
        .mret      (mret),
        .clr_missed(clr_missed),
        .cpu_intr  (sat_cpu_intr),
        .pending   (sat_pending),
        .in_service(sat_in_service),
        .missed_cnt(sat_missed_cnt),
        .proto_err (sat_proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        intr_in = 1'b1;
        tick();
        intr_in = 1'b0;
        tick();
    endtask

    task automatic ack();
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
    endtask

    task automatic do_mret();
        mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    task automatic do_reset();
        intr_in    = 1'b0;
        cpu_ack    = 1'b0;
        mret       = 1'b0;
        clr_missed = 1'b0;
        rst_n      = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        mie = 1'b1; cpu_ack = 1'b0; mret = 1'b0; clr_missed = 1'b0;
        intr_in = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({cpu_intr, pending, in_service, missed_cnt, proto_err} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %b%b%b %0d %b want all 0", cpu_intr, pending, in_service, missed_cnt, proto_err);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if ({cpu_intr, pending, missed_cnt} !== 10'h000) begin
            errors++;
            $display("FAIL release_high got cpu_intr=%b pending=%b missed=%0d want 0 0 0", cpu_intr, pending, missed_cnt);
        end
        intr_in = 1'b0;
        tick();
        $display("test_reset: line high through release, no pending");
    endtask

    task automatic test_basic();
        mie = 1'b1;
        intr_in = 1'b1;
        tick();
        checks++;
        if (pending !== 1'b1 || cpu_intr !== 1'b1) begin
            errors++;
            $display("FAIL basic_latch got pending=%b cpu_intr=%b want 1 1", pending, cpu_intr);
        end
        for (int i = 0; i < 5; i++) tick();
        intr_in = 1'b0;
        checks++;
        if (pending !== 1'b1 || missed_cnt !== 8'd0) begin
            errors++;
            $display("FAIL basic_single_edge got pending=%b missed=%0d want 1 0", pending, missed_cnt);
        end
        ack();
        checks++;
        if (in_service !== 1'b1 || cpu_intr !== 1'b0 || pending !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack got in_service=%b cpu_intr=%b pending=%b want 1 0 0", in_service, cpu_intr, pending);
        end
        do_mret();
        checks++;
        if (in_service !== 1'b0 || pending !== 1'b0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_mret got in_service=%b pending=%b proto_err=%b want 0 0 0", in_service, pending, proto_err);
        end
        $display("test_basic: 6-cycle pulse, ack, mret -> idle");
    endtask

    task automatic test_mie_gate();
        do_reset();
        mie = 1'b0;
        pulse();
        checks++;
        if (pending !== 1'b1 || cpu_intr !== 1'b0) begin
            errors++;
            $display("FAIL mie_masked got pending=%b cpu_intr=%b want 1 0", pending, cpu_intr);
        end
        ack();
        checks++;
        if (proto_err !== 1'b1 || pending !== 1'b1 || in_service !== 1'b0) begin
            errors++;
            $display("FAIL mie_bad_ack got proto_err=%b pending=%b in_service=%b want 1 1 0", proto_err, pending, in_service);
        end
        mie = 1'b1;
        #1;
        checks++;
        if (cpu_intr !== 1'b1) begin
            errors++;
            $display("FAIL mie_raise got cpu_intr=%b want 1", cpu_intr);
        end
        mie = 1'b0;
        #1;
        checks++;
        if (cpu_intr !== 1'b0) begin
            errors++;
            $display("FAIL mie_drop got cpu_intr=%b want 0", cpu_intr);
        end
        mie = 1'b1;
        ack();
        do_mret();
        checks++;
        if (pending !== 1'b0 || in_service !== 1'b0) begin
            errors++;
            $display("FAIL mie_exit got pending=%b in_service=%b want 0 0", pending, in_service);
        end
        $display("test_mie_gate: masked request, illegal ack, unmask");
    endtask

    task automatic test_proto();
        do_reset();
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_cleared got %b want 0", proto_err);
        end
        do_mret();
        checks++;
        if (proto_err !== 1'b1 || pending !== 1'b0 || in_service !== 1'b0) begin
            errors++;
            $display("FAIL proto_idle_mret got proto_err=%b pending=%b in_service=%b want 1 0 0", proto_err, pending, in_service);
        end
        do_reset();
        mie = 1'b1;
        pulse();
        ack();
        ack();
        checks++;
        if (proto_err !== 1'b1 || in_service !== 1'b1) begin
            errors++;
            $display("FAIL proto_service_ack got proto_err=%b in_service=%b want 1 1", proto_err, in_service);
        end
        do_mret();
        $display("test_proto: mret in idle and ack in service flagged");
    endtask

    task automatic test_missed();
        do_reset();
        mie = 1'b1;
        pulse();
        pulse();
        pulse();
        checks++;
        if (missed_cnt !== 8'd2 || pending !== 1'b1) begin
            errors++;
            $display("FAIL missed_pend got missed=%0d pending=%b want 2 1", missed_cnt, pending);
        end
        ack();
        pulse();
        checks++;
        if (missed_cnt !== 8'd2 || in_service !== 1'b1) begin
            errors++;
            $display("FAIL missed_repend got missed=%0d in_service=%b want 2 1", missed_cnt, in_service);
        end
        pulse();
        do_mret();
        checks++;
        if (missed_cnt !== 8'd3 || sat_missed_cnt !== 2'd3 || pending !== 1'b1 || in_service !== 1'b0) begin
            errors++;
            $display("FAIL missed_total got missed=%0d sat=%0d pending=%b in_service=%b want 3 3 1 0", missed_cnt, sat_missed_cnt, pending, in_service);
        end
        ack();
        do_mret();
        checks++;
        if (pending !== 1'b0 || in_service !== 1'b0) begin
            errors++;
            $display("FAIL missed_repend_clear got pending=%b in_service=%b want 0 0", pending, in_service);
        end
        $display("test_missed: 2 drops in pend, 1 in service, mret repends");
    endtask

    task automatic test_back_to_back();
        pulse();
        intr_in = 1'b1;
        cpu_ack = 1'b1;
        tick();
        intr_in = 1'b0;
        cpu_ack = 1'b0;
        tick();
        checks++;
        if (in_service !== 1'b1 || missed_cnt !== 8'd3) begin
            errors++;
            $display("FAIL b2b_ack_edge got in_service=%b missed=%0d want 1 3", in_service, missed_cnt);
        end
        do_mret();
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL b2b_repend got pending=%b want 1", pending);
        end
        ack();
        do_mret();
        checks++;
        if (pending !== 1'b0 || in_service !== 1'b0 || missed_cnt !== 8'd3) begin
            errors++;
            $display("FAIL b2b_exit got pending=%b in_service=%b missed=%0d want 0 0 3", pending, in_service, missed_cnt);
        end
        $display("test_back_to_back: edge with ack repends without a miss");
    endtask

    task automatic test_saturation();
        do_reset();
        mie = 1'b1;
        pulse();
        for (int i = 0; i < 6; i++) pulse();
        checks++;
        if (missed_cnt !== 8'd6 || sat_missed_cnt !== 2'd3 || sat_pending !== 1'b1) begin
            errors++;
            $display("FAIL sat_stick got missed=%0d sat=%0d sat_pending=%b want 6 3 1", missed_cnt, sat_missed_cnt, sat_pending);
        end
        clr_missed = 1'b1;
        intr_in = 1'b1;
        tick();
        clr_missed = 1'b0;
        intr_in = 1'b0;
        tick();
        checks++;
        if (missed_cnt !== 8'd0 || sat_missed_cnt !== 2'd0 || sat_in_service !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear_prio got missed=%0d sat=%0d sat_in_service=%b want 0 0 0", missed_cnt, sat_missed_cnt, sat_in_service);
        end
        checks++;
        if (sat_cpu_intr !== 1'b1 || sat_proto_err !== 1'b0) begin
            errors++;
            $display("FAIL sat_state got cpu_intr=%b proto_err=%b want 1 0", sat_cpu_intr, sat_proto_err);
        end
        $display("test_saturation: 2-bit counter sticks at 3, clear wins");
    endtask

    task automatic test_async_reset();
        do_reset();
        mie = 1'b1;
        pulse();
        ack();
        pulse();
        pulse();
        checks++;
        if (in_service !== 1'b1 || missed_cnt !== 8'd1) begin
            errors++;
            $display("FAIL async_setup got in_service=%b missed=%0d want 1 1", in_service, missed_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cpu_intr, pending, in_service, missed_cnt, proto_err} !== 12'h000) begin
            errors++;
            $display("FAIL async_assert got %b%b%b %0d %b want all 0", cpu_intr, pending, in_service, missed_cnt, proto_err);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (pending !== 1'b0 || in_service !== 1'b0 || cpu_intr !== 1'b0) begin
            errors++;
            $display("FAIL async_release got pending=%b in_service=%b cpu_intr=%b want 0 0 0", pending, in_service, cpu_intr);
        end
        $display("test_async_reset: mid-service reset discards request");
    endtask

    initial begin
        rst_n      = 1'b0;
        intr_in    = 1'b0;
        mie        = 1'b0;
        cpu_ack    = 1'b0;
        mret       = 1'b0;
        clr_missed = 1'b0;
        test_reset();
        test_basic();
        test_mie_gate();
        test_proto();
        test_missed();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
